// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and constants for the instruction fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        ERR
    } fetch_state_t;

    localparam logic [31:0] INSTR_STEP = 32'd4;
    localparam logic [1:0]  ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_watchdog.sv
// rtl/fetch_watchdog.sv - fetch request watchdog, built only with FETCH_TIMEOUT_EN
module fetch_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expire on the TIMEOUT_CYCLES-th waiting cycle so the error lands right after it.
    assign expire = enable && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage with req/ack imem read; FETCH_TIMEOUT_EN adds a request watchdog
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int INSTR_W        = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    output logic [31:0]        pc_increment,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_taken,
    input  logic [31:0]        branch_offset,
    output logic               fetch_err,
    output logic [31:0]        instr_count
);

    fetch_state_t       state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [31:0]        count_q, count_d;

    logic misaligned;
    logic accept;
    logic wd_expire;

    assign misaligned = (pc_in[1:0] & ALIGN_MASK) != 2'b00;
    assign accept     = (state_q == HOLD) && instr_ready;

`ifdef FETCH_TIMEOUT_EN
    fetch_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q != REQ),
        .enable ((state_q == REQ) && !misaligned && !imem_ack),
        .expire (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        count_d      = count_q;
        imem_req     = 1'b0;
        imem_addr    = '0;
        instr_valid  = 1'b0;
        fetch_err    = 1'b0;
        pc_increment = 32'd0;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                // PC is held steady here because the increment is forced to zero.
                imem_addr = pc_in;
                if (misaligned) begin
                    state_d = ERR;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        instr_d = imem_rdata;
                        state_d = HOLD;
                    end else if (wd_expire) begin
                        state_d = ERR;
                    end
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (accept) begin
                    count_d      = count_q + 32'd1;
                    pc_increment = branch_taken ? branch_offset : INSTR_STEP;
                    state_d      = REQ;
                end
            end
            ERR: begin
                fetch_err = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            instr_q <= '0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            count_q <= count_d;
        end
    end

    assign instr_out   = instr_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit (timeout case under FETCH_TIMEOUT_EN)
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] pc_increment;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        fetch_err;
    logic [31:0] instr_count;

    int          checks;
    int          failures;
    logic [31:0] pc_model;
    logic [31:0] count_exp;
    logic [31:0] exp_q[$];

    instr_fetch_unit #(
        .ADDR_W         (32),
        .INSTR_W        (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_in         (pc_in),
        .pc_increment  (pc_increment),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .fetch_err     (fetch_err),
        .instr_count   (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req"},   imem_req, 0);
        check_eq({tag, "_addr"},  imem_addr, 0);
        check_eq({tag, "_valid"}, instr_valid, 0);
        check_eq({tag, "_out"},   instr_out, 0);
        check_eq({tag, "_err"},   fetch_err, 0);
        check_eq({tag, "_count"}, instr_count, 0);
        check_eq({tag, "_inc"},   pc_increment, 0);
    endtask

    // Leaves the bench at a negedge with the DUT in its first REQ cycle.
    task automatic do_reset();
        reset = 1'b1;
        imem_ack = 1'b0;
        instr_ready = 1'b0;
        branch_taken = 1'b0;
        pc_model = 32'd0;
        pc_in = 32'd0;
        count_exp = 32'd0;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        #1;
        check_eq("idle_req", imem_req, 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic fetch_one(input logic [31:0] data, input int ack_dly, input int rdy_dly,
                             input logic taken, input logic [31:0] off);
        logic [31:0] inc;
        for (int d = 0; d <= ack_dly; d++) begin
            pc_in = pc_model;
            imem_ack = (d == ack_dly);
            imem_rdata = (d == ack_dly) ? data : 32'hDEADBEEF;
            branch_taken = 1'b1;
            #1;
            check_eq("req_on", imem_req, 1);
            check_eq("req_addr", imem_addr, pc_model);
            check_eq("req_inc", pc_increment, 0);
            check_eq("req_valid", instr_valid, 0);
            if (imem_ack) exp_q.push_back(data);
            @(posedge clk);
            @(negedge clk);
        end
        imem_ack = 1'b0;
        for (int r = 0; r <= rdy_dly; r++) begin
            instr_ready = (r == rdy_dly);
            branch_taken = instr_ready ? taken : 1'b1;
            branch_offset = off;
            #1;
            check_eq("hold_valid", instr_valid, 1);
            check_eq("hold_req", imem_req, 0);
            check_eq("hold_addr", imem_addr, 0);
            if (exp_q.size() == 0) check_eq("sb_empty", exp_q.size(), 1);
            else check_eq("instr_out", instr_out, exp_q[0]);
            inc = instr_ready ? (taken ? off : 32'd4) : 32'd0;
            check_eq("hold_inc", pc_increment, inc);
            if (instr_ready) begin
                void'(exp_q.pop_front());
                count_exp = count_exp + 32'd1;
                pc_model = pc_model + inc;
            end
            @(posedge clk);
            @(negedge clk);
        end
        instr_ready = 1'b0;
        branch_taken = 1'b0;
        #1;
        check_eq("count", instr_count, count_exp);
        check_eq("out_keep", instr_out, data);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        pc_in = 32'd0;
        imem_ack = 1'b0;
        imem_rdata = 32'd0;
        instr_ready = 1'b0;
        branch_taken = 1'b0;
        branch_offset = 32'd0;
        pc_model = 32'd0;
        count_exp = 32'd0;

        do_reset();
        fetch_one(32'h00500093, 0, 0, 1'b0, 32'd0);
        fetch_one(32'h00A00113, 3, 0, 1'b0, 32'd0);
        fetch_one(32'h002081B3, 0, 5, 1'b0, 32'd0);
        fetch_one(32'hFE000CE3, 1, 1, 1'b1, 32'hFFFFFFF8);
        fetch_one(32'h00310233, 0, 0, 1'b0, 32'd0);

        // Reset in the middle of a request drops imem_req at once; a late ack is ignored.
        pc_in = pc_model;
        #1;
        check_eq("mid_req_on", imem_req, 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b1;
        imem_rdata = 32'h12345678;
        pc_model = 32'd0;
        pc_in = 32'd0;
        count_exp = 32'd0;
        exp_q.delete();
        reset = 1'b0;
        #1;
        check_eq("late_ack_idle_req", imem_req, 0);
        check_eq("late_ack_idle_valid", instr_valid, 0);
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        check_eq("late_ack_req", imem_req, 1);
        check_eq("late_ack_valid", instr_valid, 0);
        fetch_one(32'h00000013, 0, 0, 1'b0, 32'd0);

        // A taken branch to a misaligned target faults on the following REQ.
        fetch_one(32'h0020006F, 0, 0, 1'b1, 32'd2);
        pc_in = pc_model;
        #1;
        check_eq("mis_req", imem_req, 0);
        check_eq("mis_addr", imem_addr, pc_model);
        check_eq("mis_err_pre", fetch_err, 0);
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1;
            instr_ready = 1'b1;
            branch_taken = 1'b1;
            #1;
            check_eq("err_sticky", fetch_err, 1);
            check_eq("err_req", imem_req, 0);
            check_eq("err_valid", instr_valid, 0);
            check_eq("err_inc", pc_increment, 0);
            check_eq("err_count", instr_count, count_exp);
            @(posedge clk);
            @(negedge clk);
        end
        do_reset();
        check_eq("err_cleared", fetch_err, 0);

`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            pc_in = pc_model;
            imem_ack = 1'b0;
            #1;
            check_eq("wd_req", imem_req, 1);
            check_eq("wd_err_pre", fetch_err, 0);
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        check_eq("wd_err", fetch_err, 1);
        check_eq("wd_req_off", imem_req, 0);
        do_reset();
`endif

        fetch_one(32'h00B00293, 2, 2, 1'b0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage between the program counter and decode/execute in the 32-bit non-pipelined core.
- Consumes the PC value and issues a word read to instruction memory with a req/ack handshake.
- Holds the returned instruction until decode accepts it.
- Drives the PC's increment input: 0 while stalled, 4 on accept, or the branch offset on a taken branch.

Parameters:
- ADDR_W, 32, PC and instruction-memory address width.
- INSTR_W, 32, instruction word width.
- TIMEOUT_CYCLES, 256, cycles in REQ without imem_ack before a fetch error (only with FETCH_TIMEOUT_EN).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- pc_in  input  ADDR_W  current PC from the program counter.
- pc_increment  output  32  increment for the program counter; combinational.
- imem_req  output  1  read request to instruction memory.
- imem_addr  output  ADDR_W  read address.
- imem_ack  input  1  memory has returned data this cycle.
- imem_rdata  input  INSTR_W  read data; valid when imem_ack=1.
- instr_out  output  INSTR_W  fetched instruction.
- instr_valid  output  1  instr_out is valid.
- instr_ready  input  1  decode accepts instr_out.
- branch_taken  input  1  the instruction being accepted is a taken branch.
- branch_offset  input  32  signed byte offset applied to the PC on a taken branch.
- fetch_err  output  1  sticky fault flag.
- instr_count  output  32  count of accepted instructions; wraps.

Behaviour:
- Reset: asynchronous, active-high; clock clk.
- Reset values:
  - state=IDLE
  - instr_out=0, instr_valid=0
  - imem_req=0
  - fetch_err=0
  - instr_count=0
  - pc_increment=0
- Reset mid-operation aborts any request and drops imem_req immediately; a late ack is ignored.
- States:
  - IDLE: exactly one cycle after reset release; go to REQ.
  - REQ:
    - imem_addr=pc_in (combinational; the PC is stable because increment=0).
    - imem_req=1 only when pc_in[1:0]==0.
    - If pc_in[1:0]!=0: imem_req=0 and go to ERR.
    - Else on imem_ack=1: capture imem_rdata into instr_out and go to HOLD.
    - Else stay in REQ.
  - HOLD:
    - instr_valid=1.
    - On instr_ready=1 (accept): instr_count+=1 and go to REQ.
    - Else hold; instr_out stays stable.
  - ERR:
    - fetch_err=1, imem_req=0, instr_valid=0, pc_increment=0.
    - Exit only by reset.
- Outside REQ: imem_req=0 and imem_addr=0.
- pc_increment:
  - 0 unless an accept occurs this cycle.
  - On accept: branch_offset if branch_taken, else 4.
  - branch_taken is ignored when there is no accept.
- Timing:
  - Minimum 2 cycles per instruction (ack in the first REQ cycle, ready in the first HOLD cycle).
  - The PC updates at the accept edge, so the next REQ sees the new pc_in.
- imem_ack outside REQ is ignored.
- instr_out keeps its last value after accept.
- instr_count wraps 32'hFFFFFFFF -> 0.
- Branch offsets are added modulo 2^32 by the PC. A misaligned branch target is caught on the next REQ.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With the macro:
  - A watchdog counter clears on REQ entry and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES, go to ERR; an ack in that same cycle takes priority.
- Without the macro: REQ waits indefinitely, the counter is not built, and TIMEOUT_CYCLES is unused.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum {IDLE, REQ, HOLD, ERR}
  - INSTR_STEP=32'd4
  - ALIGN_MASK=2'b11
- One sub-module, fetch_watchdog (counter, clear, enable, expire), instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Reset then pc_in=0, ack same cycle with rdata=32'h00500093, ready=1 -> instr_valid at cycle 2 with instr_out=32'h00500093, pc_increment=4 that cycle, instr_count=1.
- Ack delayed 3 cycles -> imem_req held 4 cycles with imem_addr stable and pc_increment=0 throughout.
- HOLD with instr_ready=0 for 5 cycles -> instr_out and instr_valid stable, pc_increment=0, then ready=1 -> single increment of 4.
- Accept with branch_taken=1, branch_offset=32'hFFFFFFF8 -> pc_increment=32'hFFFFFFF8; next REQ imem_addr=old PC-8.
- pc_in=32'h00000006 in REQ -> imem_req=0, fetch_err=1 next cycle and sticky; reset clears it to IDLE.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=8, no ack -> ERR after 8 REQ cycles; reset asserted mid-REQ -> imem_req drops immediately, all outputs at reset values.
